// File: rtl/mips_multiciclo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multiciclo_ctrl_if
// Brief    : Control bundle between the multicycle MIPS controller and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multiciclo_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       instrucc;
   logic [5:0]       CampoFuncion;
   logic             zero;
   logic             mem_listo;
   logic             RegDest;
   logic             LeerMem;
   logic             MemaReg;
   logic             EscrMem;
   logic             FuenteALU;
   logic             EscrReg;
   logic             FuentePC;
   logic             EscrPC;
   logic [2:0]       ControlALU;
   logic             ilegal;
   logic             err_mem;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  instrucc, CampoFuncion, zero, mem_listo,
      output RegDest, LeerMem, MemaReg, EscrMem, FuenteALU, EscrReg,
             FuentePC, EscrPC, ControlALU, ilegal, err_mem, instr_count
   );

   modport slave (
      output instrucc, CampoFuncion, zero, mem_listo,
      input  RegDest, LeerMem, MemaReg, EscrMem, FuenteALU, EscrReg,
             FuentePC, EscrPC, ControlALU, ilegal, err_mem, instr_count
   );
endinterface
`default_nettype wire

// File: rtl/mips_multiciclo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multiciclo_ctrl
// Brief    : Multicycle MIPS32 control FSM with memory-ready timeout and
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multiciclo_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input wire logic              clk,
   input wire logic              reset,
   mips_multiciclo_ctrl_if.master bus
);

   localparam logic [5:0] c_OP_R    = 6'b000000;
   localparam logic [5:0] c_OP_LW   = 6'b100011;
   localparam logic [5:0] c_OP_SW   = 6'b101011;
   localparam logic [5:0] c_OP_BEQ  = 6'b000100;
   localparam logic [5:0] c_OP_ADDI = 6'b001000;

   localparam logic [5:0] c_F_ADD = 6'b100000;
   localparam logic [5:0] c_F_SUB = 6'b100010;
   localparam logic [5:0] c_F_AND = 6'b100100;
   localparam logic [5:0] c_F_OR  = 6'b100101;
   localparam logic [5:0] c_F_SLT = 6'b101010;

   localparam logic [2:0] c_ALU_ADD = 3'b010;
   localparam logic [2:0] c_ALU_SUB = 3'b110;
   localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEMADDR,
      MEM_RD, WB_MEM, MEM_WR, BRANCH, ILEGAL, TIMEOUT
   } state_t;

   typedef struct packed {
      logic       regDest;
      logic       leerMem;
      logic       memaReg;
      logic       escrMem;
      logic       fuenteALU;
      logic       escrReg;
      logic       branch;
      logic       escrPC;
      logic [2:0] aluOp;
      logic       ilegal;
      logic       errMem;
   } ctrl_t;

   function automatic logic [2:0] aluFromFunct(input logic [5:0] fn);
      case (fn)
         c_F_ADD: return c_ALU_ADD;
         c_F_SUB: return c_ALU_SUB;
         c_F_AND: return 3'b000;
         c_F_OR:  return 3'b001;
         c_F_SLT: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic functLegal(input logic [5:0] fn);
      return (fn == c_F_ADD) || (fn == c_F_SUB) || (fn == c_F_AND) ||
             (fn == c_F_OR)  || (fn == c_F_SLT);
   endfunction

   // Moore outputs of the state being entered, so they appear registered
   function automatic ctrl_t ctrlFor(input state_t s, input logic [5:0] fn);
      ctrl_t c;
      c = '0;
      case (s)
         EXEC_R:  c.aluOp = aluFromFunct(fn);
         WB_R: begin
            c.regDest = 1'b1; c.escrReg = 1'b1; c.escrPC = 1'b1;
            c.aluOp   = aluFromFunct(fn);
         end
         EXEC_I, MEMADDR: begin
            c.fuenteALU = 1'b1; c.aluOp = c_ALU_ADD;
         end
         WB_I: begin
            c.fuenteALU = 1'b1; c.aluOp = c_ALU_ADD;
            c.escrReg   = 1'b1; c.escrPC = 1'b1;
         end
         MEM_RD: begin
            c.fuenteALU = 1'b1; c.aluOp = c_ALU_ADD; c.leerMem = 1'b1;
         end
         WB_MEM: begin
            c.fuenteALU = 1'b1; c.aluOp   = c_ALU_ADD; c.leerMem = 1'b1;
            c.memaReg   = 1'b1; c.escrReg = 1'b1;      c.escrPC  = 1'b1;
         end
         MEM_WR: begin
            c.fuenteALU = 1'b1; c.aluOp = c_ALU_ADD; c.escrMem = 1'b1;
         end
         BRANCH: begin
            c.aluOp = c_ALU_SUB; c.escrPC = 1'b1; c.branch = 1'b1;
         end
         ILEGAL:  begin c.ilegal = 1'b1; c.escrPC = 1'b1; end
         TIMEOUT: begin c.errMem = 1'b1; c.escrPC = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t           r_state;
   logic [5:0]       r_op;
   logic [5:0]       r_funct;
   logic [7:0]       r_waitCnt;
   ctrl_t            r_ctrl;
   logic [CNT_W-1:0] r_count;

   state_t     w_next;
   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic [7:0] w_waitCnt;
   logic       w_retire;

   always_comb begin
      w_next    = r_state;
      w_op      = r_op;
      w_funct   = r_funct;
      w_waitCnt = r_waitCnt;
      w_retire  = 1'b0;
      case (r_state)
         FETCH: w_next = DECODE;
         DECODE: begin
            w_op    = bus.instrucc;
            w_funct = bus.CampoFuncion;
            case (bus.instrucc)
               c_OP_R:          w_next = functLegal(bus.CampoFuncion) ? EXEC_R : ILEGAL;
               c_OP_ADDI:       w_next = EXEC_I;
               c_OP_LW, c_OP_SW: w_next = MEMADDR;
               c_OP_BEQ:        w_next = BRANCH;
               default:         w_next = ILEGAL;
            endcase
         end
         EXEC_R: w_next = WB_R;
         EXEC_I: w_next = WB_I;
         MEMADDR: begin
            w_waitCnt = 8'd0;
            w_next    = (r_op == c_OP_LW) ? MEM_RD : MEM_WR;
         end
         // Ready takes priority over a timeout reached in the same cycle
         MEM_RD, MEM_WR: begin
            if (bus.mem_listo) begin
               w_next   = (r_state == MEM_RD) ? WB_MEM : FETCH;
               w_retire = (r_state == MEM_WR);
            end else if (r_waitCnt == c_WAIT_LAST) begin
               w_next = TIMEOUT;
            end else begin
               w_waitCnt = r_waitCnt + 8'd1;
            end
         end
         WB_R, WB_I, WB_MEM, BRANCH: begin
            w_next   = FETCH;
            w_retire = 1'b1;
         end
         ILEGAL, TIMEOUT: w_next = FETCH;
         default:         w_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= FETCH;
         r_op      <= 6'd0;
         r_funct   <= 6'd0;
         r_waitCnt <= 8'd0;
         r_ctrl    <= '0;
         r_count   <= '0;
      end else begin
         r_state   <= w_next;
         r_op      <= w_op;
         r_funct   <= w_funct;
         r_waitCnt <= w_waitCnt;
         r_ctrl    <= ctrlFor(w_next, w_funct);
         if (w_retire) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign bus.RegDest     = r_ctrl.regDest;
   assign bus.LeerMem     = r_ctrl.leerMem;
   assign bus.MemaReg     = r_ctrl.memaReg;
   assign bus.EscrMem     = r_ctrl.escrMem;
   assign bus.FuenteALU   = r_ctrl.fuenteALU;
   assign bus.EscrReg     = r_ctrl.escrReg;
   assign bus.FuentePC    = r_ctrl.branch & bus.zero;
   // A store completes in MEM_WR itself, so its PC load follows mem_listo
   assign bus.EscrPC      = r_ctrl.escrPC | ((r_state == MEM_WR) & bus.mem_listo);
   assign bus.ControlALU  = r_ctrl.aluOp;
   assign bus.ilegal      = r_ctrl.ilegal;
   assign bus.err_mem     = r_ctrl.errMem;
   assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_multiciclo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multiciclo_ctrl
// Brief    : Scoreboard bench for the multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multiciclo_ctrl;

   localparam int c_CNT_W = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mips_multiciclo_ctrl_if #(.CNT_W(c_CNT_W)) bus ();

   mips_multiciclo_ctrl #(.MEM_TIMEOUT(15), .CNT_W(c_CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int         id;
      int         lat;
      logic       rd, mr, fa, er, fp;
      logic [2:0] alu;
      logic       ilg, err;
      int         leer, escrM, regW;
      logic [3:0] cnt;
   } exp_t;

   exp_t       expQ[$];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] expCnt = 4'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: an instruction ends on its EscrPC cycle
   int cyc = 0, mLeer = 0, mEscrM = 0, mRegW = 0;
   always @(negedge clk) begin
      if (!reset) begin
         cyc = 0; mLeer = 0; mEscrM = 0; mRegW = 0;
      end else begin
         cyc++;
         mLeer  += int'(bus.LeerMem);
         mEscrM += int'(bus.EscrMem);
         mRegW  += int'(bus.EscrReg);
         if (bus.EscrPC) begin
            if (expQ.size() == 0) begin
               check("unexpected_EscrPC", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               check($sformatf("i%0d_latency", e.id),   cyc,             e.lat);
               check($sformatf("i%0d_RegDest", e.id),   bus.RegDest,     e.rd);
               check($sformatf("i%0d_MemaReg", e.id),   bus.MemaReg,     e.mr);
               check($sformatf("i%0d_FuenteALU", e.id), bus.FuenteALU,   e.fa);
               check($sformatf("i%0d_EscrReg", e.id),   bus.EscrReg,     e.er);
               check($sformatf("i%0d_FuentePC", e.id),  bus.FuentePC,    e.fp);
               check($sformatf("i%0d_ControlALU", e.id), bus.ControlALU, e.alu);
               check($sformatf("i%0d_ilegal", e.id),    bus.ilegal,      e.ilg);
               check($sformatf("i%0d_err_mem", e.id),   bus.err_mem,     e.err);
               check($sformatf("i%0d_LeerMem_cycles", e.id), mLeer,      e.leer);
               check($sformatf("i%0d_EscrMem_cycles", e.id), mEscrM,     e.escrM);
               check($sformatf("i%0d_EscrReg_cycles", e.id), mRegW,      e.regW);
               check($sformatf("i%0d_instr_count", e.id), bus.instr_count, e.cnt);
            end
            cyc = 0; mLeer = 0; mEscrM = 0; mRegW = 0;
         end
      end
   end

   // Called at the start of the FETCH cycle; returns at the start of the next FETCH
   task automatic issue(input int id, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int waits, input int lat,
                        input logic rd, input logic mr, input logic fa, input logic er,
                        input logic fp, input logic [2:0] alu, input logic ilg,
                        input logic err, input int leer, input int escrM, input bit retire);
      exp_t e;
      int   n;
      e.id = id; e.lat = lat; e.rd = rd; e.mr = mr; e.fa = fa; e.er = er; e.fp = fp;
      e.alu = alu; e.ilg = ilg; e.err = err; e.leer = leer; e.escrM = escrM;
      e.regW = int'(er); e.cnt = expCnt;
      expQ.push_back(e);
      if (retire) expCnt = expCnt + 4'd1;
      bus.instrucc = op; bus.CampoFuncion = fn; bus.zero = z; bus.mem_listo = 1'b0;
      n = 0;
      for (int k = 0; k < lat; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         bus.mem_listo = 1'b0;
         if (bus.LeerMem || bus.EscrMem) begin
            if (n == waits) bus.mem_listo = 1'b1;
            n++;
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [12:0] allOuts();
      return {bus.RegDest, bus.LeerMem, bus.MemaReg, bus.EscrMem, bus.FuenteALU,
              bus.EscrReg, bus.FuentePC, bus.EscrPC, bus.ControlALU, bus.ilegal, bus.err_mem};
   endfunction

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                          BEQ = 6'b000100, ADDI = 6'b001000;

   initial begin
      bus.instrucc = '0; bus.CampoFuncion = '0; bus.zero = 1'b0; bus.mem_listo = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", allOuts(), 13'd0);
      check("reset_count", bus.instr_count, 4'd0);

      // Start a lw and abort it while it waits in MEM_RD
      reset = 1'b1;
      bus.instrucc = LW;
      repeat (3) @(posedge clk);
      #1;
      check("pre_abort_LeerMem", bus.LeerMem, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("abort_outputs", allOuts(), 13'd0);
      check("abort_count", bus.instr_count, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      check("held_reset_outputs", allOuts(), 13'd0);
      reset = 1'b1;

      //    id op    funct      z  w   lat rd mr fa er fp alu     ilg err leer escrM ret
      issue(1,  R,   6'b100000, 0, -1, 4,  1, 0, 0, 1, 0, 3'b010, 0, 0,  0,   0,  1);
      issue(2,  BEQ, 6'b000000, 1, -1, 3,  0, 0, 0, 0, 1, 3'b110, 0, 0,  0,   0,  1);
      issue(3,  BEQ, 6'b000000, 0, -1, 3,  0, 0, 0, 0, 0, 3'b110, 0, 0,  0,   0,  1);
      issue(4,  LW,  6'b000000, 0,  3, 8,  0, 1, 1, 1, 0, 3'b010, 0, 0,  5,   0,  1);
      issue(5,  SW,  6'b000000, 0, -1, 19, 0, 0, 0, 0, 0, 3'b000, 0, 1,  0,  15,  0);
      issue(6,  6'b111111, 6'b000000, 0, -1, 3, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0);
      issue(7,  R,   6'b000111, 0, -1, 3,  0, 0, 0, 0, 0, 3'b000, 1, 0,  0,   0,  0);
      issue(8,  SW,  6'b000000, 0,  2, 6,  0, 0, 1, 0, 0, 3'b010, 0, 0,  0,   3,  1);
      issue(9,  ADDI,6'b000000, 0, -1, 4,  0, 0, 1, 1, 0, 3'b010, 0, 0,  0,   0,  1);
      issue(10, R,   6'b100010, 0, -1, 4,  1, 0, 0, 1, 0, 3'b110, 0, 0,  0,   0,  1);
      issue(11, R,   6'b100100, 0, -1, 4,  1, 0, 0, 1, 0, 3'b000, 0, 0,  0,   0,  1);
      issue(12, R,   6'b100101, 0, -1, 4,  1, 0, 0, 1, 0, 3'b001, 0, 0,  0,   0,  1);
      issue(13, R,   6'b101010, 0, -1, 4,  1, 0, 0, 1, 0, 3'b111, 0, 0,  0,   0,  1);
      issue(14, LW,  6'b000000, 0,  0, 5,  0, 1, 1, 1, 0, 3'b010, 0, 0,  2,   0,  1);
      issue(15, SW,  6'b000000, 0, 14, 18, 0, 0, 1, 0, 0, 3'b010, 0, 0,  0,  15,  1);
      issue(16, LW,  6'b000000, 0, 14, 19, 0, 1, 1, 1, 0, 3'b010, 0, 0, 16,   0,  1);
      for (int i = 0; i < 5; i++) begin
         issue(17 + i, R, 6'b100000, 0, -1, 4, 1, 0, 0, 1, 0, 3'b010, 0, 0, 0, 0, 1);
      end

      check("final_count_after_wrap", bus.instr_count, expCnt);
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_multiciclo_ctrl.md
Name: mips_multiciclo_ctrl

Overview:
Multicycle control unit for the MIPS32 datapath. It drives the datapath control lines (RegDest, LeerMem, MemaReg, EscrMem, FuenteALU, EscrReg, FuentePC, ControlALU) plus a new PC write enable, so that each instruction runs over several clock states instead of one.
It decodes instrucc/CampoFuncion and samples zero.
It waits on a data-memory ready handshake, with a timeout.
It counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles in a memory state before abort (1..255).
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
instrucc  in  6  opcode, instruccion[31:26].
CampoFuncion  in  6  funct, instruccion[5:0].
zero  in  1  ALU zero flag.
mem_listo  in  1  dmem ready: read data valid / write accepted this cycle.
RegDest  out  1  0 = rt, 1 = rd write address.
LeerMem  out  1  dmem read enable.
MemaReg  out  1  1 = write-back from dmem.
EscrMem  out  1  dmem write enable.
FuenteALU  out  1  1 = sign-extended immediate into ALU b.
EscrReg  out  1  regfile write enable.
FuentePC  out  1  1 = branch target.
EscrPC  out  1  PC register load enable (one pulse per instruction).
ControlALU  out  3  ALU operation.
ilegal  out  1  one-cycle pulse: unsupported opcode/funct.
err_mem  out  1  one-cycle pulse: memory timeout.
instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (reset=0, async): state=FETCH, all outputs 0, instr_count=0, wait counter=0, latched op/funct=0. Any state is aborted immediately; no partial write completes after reset is released.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000.
- R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- ControlALU encoding: and 000, or 001, add 010, sub 110, slt 111.
- DECODE registers op/funct. All later states decode from these registered values.
- Outputs are Moore: a function of state and registered op/funct only. zero and mem_listo only steer transitions and FuentePC.
- Unlisted outputs are 0 in each state.
- States and transitions:
  - FETCH: no outputs -> DECODE.
  - DECODE: latch op/funct.
    - R legal -> EXEC_R; addi -> EXEC_I; lw/sw -> MEMADDR; beq -> BRANCH.
    - Illegal -> ILEGAL.
  - EXEC_R: ControlALU from funct -> WB_R.
  - WB_R: RegDest=1, EscrReg=1, ControlALU from funct, EscrPC=1 -> FETCH.
  - EXEC_I: FuenteALU=1, ControlALU=010 -> WB_I.
  - WB_I: FuenteALU=1, ControlALU=010, EscrReg=1, EscrPC=1 -> FETCH.
  - MEMADDR: FuenteALU=1, ControlALU=010 -> MEM_RD (lw) / MEM_WR (sw). Wait counter cleared.
  - MEM_RD: FuenteALU=1, ControlALU=010, LeerMem=1.
    - mem_listo=1 -> WB_MEM.
    - Else wait counter +1. At count == MEM_TIMEOUT with no ready -> TIMEOUT.
  - WB_MEM: MEM_RD drives held, MemaReg=1, EscrReg=1, EscrPC=1 -> FETCH.
  - MEM_WR: FuenteALU=1, ControlALU=010, EscrMem=1.
    - mem_listo=1 -> EscrPC=1 this cycle, retire -> FETCH.
    - Timeout rule same as MEM_RD.
  - BRANCH: ControlALU=110, EscrPC=1, FuentePC=zero -> FETCH.
  - ILEGAL: ilegal=1, EscrPC=1 (skip instruction), no writes, not counted -> FETCH.
  - TIMEOUT: err_mem=1, EscrPC=1, no reg/mem write, not counted -> FETCH.
- mem_listo on the same cycle the timeout is reached: ready wins (normal completion).
- Latency in cycles: R/addi 4; beq 3; lw 5 + waits; sw 4 + waits; illegal 3; timeout = 4 + MEM_TIMEOUT.
- instr_count increments on the EscrPC edge of retired (legal, non-timeout) instructions. It wraps modulo 2^CNT_W.
- EscrPC is asserted exactly once per instruction, in its final state. The PC does not change mid-instruction.

Test Plan:
- Reset held low mid-MEM_RD, then released -> all outputs 0 while low; first post-reset cycle is FETCH; instr_count=0.
- R add (op 000000, funct 100000) -> states FETCH, DECODE, EXEC_R, WB_R; WB_R drives RegDest=1, EscrReg=1, ControlALU=010, EscrPC=1; instr_count 0->1.
- beq: zero=1 -> BRANCH drives FuentePC=1, EscrPC=1, ControlALU=110. Repeat with zero=0 -> FuentePC=0. Each takes 3 cycles.
- lw with mem_listo low 3 cycles then high -> LeerMem=1 for 4 MEM_RD cycles; WB_MEM drives MemaReg=1, EscrReg=1; total 8 cycles.
- sw with mem_listo never asserted, MEM_TIMEOUT=15 -> EscrMem high 15 cycles, then err_mem=1 for one cycle; EscrReg never 1; instr_count unchanged.
- Illegal op 111111, then funct 000111 with op 000000 -> ilegal pulses once each, EscrPC=1, no EscrReg/EscrMem, count unchanged. Also check instr_count wrap at CNT_W=4 after 16 retires -> 0.
